// File: rtl/el2_trace_buf.sv
// el2_trace_buf: elastic FIFO for retired-instruction trace packets.
// Captures one packet per cycle from commit, drains in order over a
// valid/ready handshake, drops on full and flags the loss in-band on the
// next stored packet.
//
// Optional feature macro: EL2_TRACE_OVF_CNT_EN
//   defined   -> 16-bit saturating drop counter on ovf_cnt, cleared by ovf_cnt_clr
//   undefined -> ovf_cnt tied to 0, ovf_cnt_clr ignored (ports kept)

package el2_trace_pkg;

  // 104-bit retired-instruction trace packet.
  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

endpackage

module el2_trace_buf
  import el2_trace_pkg::*;
#(
  parameter int DEPTH = 4  // power of 2, >= 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  el2_trace_pkt_t             trace_in,
  output logic                       trace_out_valid,
  output el2_trace_pkt_t             trace_out,
  output logic                       trace_out_ovf,
  input  logic                       trace_out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  input  logic                       ovf_cnt_clr,
  output logic [15:0]                ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake (output side): the head entry transfers on a cycle where
  // trace_out_valid and trace_out_ready are both high at the rising edge.
  // While valid is high and ready is low, trace_out/trace_out_ovf hold.
  // Valid never depends on ready. The input side has no backpressure:
  // a push that cannot be stored is dropped and flagged.

  // One storage entry: overflow marker plus the untouched packet.
  typedef struct packed {
    logic           ovf;
    el2_trace_pkt_t pkt;
  } entry_t;

  entry_t          mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_pending_q, ovf_pending_d;

  logic            empty;
  logic            full;
  logic            push_req;
  logic            pop;
  logic            push_acc;
  logic            drop;
  entry_t          head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = trace_en & trace_in.trace_rv_i_valid_ip;

  // Valid comes only from registered occupancy, so a push is never
  // visible in the same cycle (no fall-through).
  assign trace_out_valid = ~empty;
  assign pop             = trace_out_valid & trace_out_ready;

  // A push into a full buffer still fits when the head leaves this cycle.
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Next-state for pointers, occupancy and the pending-overflow flag.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    ovf_pending_d = ovf_pending_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The stored packet carries the loss marker, so accepting a push
    // consumes it; a drop arms it for the next accepted packet.
    if (push_acc) begin
      ovf_pending_d = 1'b0;
    end else if (drop) begin
      ovf_pending_d = 1'b1;
    end
  end

  // Control state registers, discarded immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_pending_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ovf_pending_q <= ovf_pending_d;
    end
  end

  // Packet storage; no reset, contents are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= {ovf_pending_q, trace_in};
    end
  end

  // Head entry is presented directly from storage. When empty the packet
  // is whatever was last held there; the ovf flag is forced low so it
  // reads 0 out of reset.
  assign head          = mem_q[rd_ptr_q];
  assign trace_out     = head.pkt;
  assign trace_out_ovf = head.ovf & ~empty;
  assign fifo_count    = count_q;

`ifdef EL2_TRACE_OVF_CNT_EN

  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Drop counter next-state: clear has priority, then saturating increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_cnt_clr) begin
      ovf_cnt_d = '0;
    end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;

`else

  // Counter absent: port kept for integration, clear input has no effect.
  logic unused_ovf_cnt_clr;
  assign unused_ovf_cnt_clr = ovf_cnt_clr;
  assign ovf_cnt            = '0;

`endif

endmodule

// File: tb/tb_el2_trace_buf.sv
// Directed testbench for el2_trace_buf (DEPTH=4). Build with or without
// EL2_TRACE_OVF_CNT_EN; counter expectations follow the macro.

module tb_el2_trace_buf;
  import el2_trace_pkg::*;

  localparam int DEPTH = 4;

`ifdef EL2_TRACE_OVF_CNT_EN
  localparam bit CNT_ON    = 1'b1;
  localparam int SAT_DROPS = 65540;
`else
  localparam bit CNT_ON    = 1'b0;
  localparam int SAT_DROPS = 10;
`endif

  logic            clk;
  logic            rst;
  logic            trace_en;
  el2_trace_pkt_t  trace_in;
  logic            trace_out_valid;
  el2_trace_pkt_t  trace_out;
  logic            trace_out_ovf;
  logic            trace_out_ready;
  logic [2:0]      fifo_count;
  logic            ovf_cnt_clr;
  logic [15:0]     ovf_cnt;

  int checks;
  int errors;

  el2_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .trace_en        (trace_en),
    .trace_in        (trace_in),
    .trace_out_valid (trace_out_valid),
    .trace_out       (trace_out),
    .trace_out_ovf   (trace_out_ovf),
    .trace_out_ready (trace_out_ready),
    .fifo_count      (fifo_count),
    .ovf_cnt_clr     (ovf_cnt_clr),
    .ovf_cnt         (ovf_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a fully populated valid packet from an instruction word.
  function automatic el2_trace_pkt_t mk_pkt(input logic [31:0] insn);
    el2_trace_pkt_t p;
    p.trace_rv_i_insn_ip      = insn;
    p.trace_rv_i_address_ip   = (insn << 2) ^ 32'h8000_0000;
    p.trace_rv_i_valid_ip     = 1'b1;
    p.trace_rv_i_exception_ip = insn[0];
    p.trace_rv_i_ecause_ip    = insn[5:1];
    p.trace_rv_i_interrupt_ip = insn[1];
    p.trace_rv_i_tval_ip      = ~insn;
    return p;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; trace_en = 1'b0; trace_in = '0; trace_out_ready = 1'b0; ovf_cnt_clr = 1'b0;
    step(); step();
    checks++; if (trace_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", trace_out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (trace_out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", trace_out_ovf); end
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf_cnt: got %h expected 0", ovf_cnt); end
    rst = 1'b0;
    step();
    checks++; if (trace_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", trace_out_valid); end
  endtask

  task automatic test_single_push();
    trace_in = mk_pkt(32'h0000_0013); trace_en = 1'b1; trace_out_ready = 1'b1;
    #1;
    checks++; if (trace_out_valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough: got %b expected 0", trace_out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d expected 0", fifo_count); end
    step();
    trace_en = 1'b0;
    checks++; if (trace_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", trace_out_valid); end
    checks++; if (trace_out !== mk_pkt(32'h0000_0013)) begin errors++; $display("FAIL single_data: got %h expected %h", trace_out, mk_pkt(32'h0000_0013)); end
    checks++; if (trace_out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b expected 0", trace_out_ovf); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", fifo_count); end
    step();
    checks++; if (trace_out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", trace_out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_back: got %0d expected 0", fifo_count); end
    step();
    checks++; if (trace_out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b expected 0", trace_out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_insn [5];
    logic        exp_ovf  [5];
    trace_out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      trace_in = mk_pkt(32'h100 + 32'(i));
      step();
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_full_count: got %0d expected 4", fifo_count); end
    checks++; if (ovf_cnt !== (CNT_ON ? 16'd2 : 16'd0)) begin errors++; $display("FAIL ovf_cnt_two: got %0d expected %0d", ovf_cnt, CNT_ON ? 2 : 0); end
    // raise ready and push G in the same cycle
    trace_out_ready = 1'b1; trace_in = mk_pkt(32'h106);
    exp_insn = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h106};
    exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      checks++; if (trace_out_valid !== 1'b1 || trace_out !== mk_pkt(exp_insn[i])) begin errors++; $display("FAIL ovf_order[%0d]: got v=%b %h expected %h", i, trace_out_valid, trace_out.trace_rv_i_insn_ip, exp_insn[i]); end
      checks++; if (trace_out_ovf !== exp_ovf[i]) begin errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, trace_out_ovf, exp_ovf[i]); end
      step();
      trace_en = 1'b0;
    end
    checks++; if (trace_out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_drained: got v=%b cnt=%0d expected v=0 cnt=0", trace_out_valid, fifo_count); end
  endtask

  task automatic test_full_push_pop();
    trace_out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trace_in = mk_pkt(32'h200 + 32'(i));
      step();
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fpp_fill: got %0d expected 4", fifo_count); end
    trace_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trace_in = mk_pkt(32'h204 + 32'(i));
      checks++; if (trace_out !== mk_pkt(32'h200 + 32'(i))) begin errors++; $display("FAIL fpp_head[%0d]: got %h expected %h", i, trace_out.trace_rv_i_insn_ip, 32'h200 + 32'(i)); end
      step();
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fpp_count[%0d]: got %0d expected 4", i, fifo_count); end
    end
    trace_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_out_valid !== 1'b1 || trace_out !== mk_pkt(32'h203 + 32'(i)) || trace_out_ovf !== 1'b0) begin errors++; $display("FAIL fpp_drain[%0d]: got v=%b %h ovf=%b expected %h ovf=0", i, trace_out_valid, trace_out.trace_rv_i_insn_ip, trace_out_ovf, 32'h203 + 32'(i)); end
      step();
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL fpp_empty: got %0d expected 0", fifo_count); end
    checks++; if (ovf_cnt !== (CNT_ON ? 16'd2 : 16'd0)) begin errors++; $display("FAIL fpp_no_drop: got %0d expected %0d", ovf_cnt, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_backpressure();
    el2_trace_pkt_t junk;
    trace_out_ready = 1'b0; trace_en = 1'b1;
    trace_in = mk_pkt(32'h300); step();
    trace_in = mk_pkt(32'h301); step();
    // enable stays high but packets are unqualified: nothing may enter
    for (int i = 0; i < 10; i++) begin
      junk = mk_pkt($urandom_range(32'hFFFF, 0));
      junk.trace_rv_i_valid_ip = 1'b0;
      trace_in = junk;
      step();
      checks++; if (trace_out !== mk_pkt(32'h300) || trace_out_ovf !== 1'b0 || fifo_count !== 3'd2) begin errors++; $display("FAIL bp_hold[%0d]: got %h ovf=%b cnt=%0d expected 300 ovf=0 cnt=2", i, trace_out.trace_rv_i_insn_ip, trace_out_ovf, fifo_count); end
    end
    trace_en = 1'b0; trace_out_ready = 1'b1;
    step();
    checks++; if (trace_out_valid !== 1'b1 || trace_out !== mk_pkt(32'h301)) begin errors++; $display("FAIL bp_pop1: got v=%b %h expected 301", trace_out_valid, trace_out.trace_rv_i_insn_ip); end
    step();
    checks++; if (trace_out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL bp_pop2: got v=%b cnt=%0d expected v=0 cnt=0", trace_out_valid, fifo_count); end
  endtask

  task automatic test_en_off_pending();
    trace_out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      trace_in = mk_pkt(32'h400 + 32'(i));
      step();
    end
    checks++; if (ovf_cnt !== (CNT_ON ? 16'd3 : 16'd0)) begin errors++; $display("FAIL en_drop_cnt: got %0d expected %0d", ovf_cnt, CNT_ON ? 3 : 0); end
    // drain completely with capture disabled; loss marker must survive
    trace_en = 1'b0; trace_out_ready = 1'b1;
    repeat (7) step();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL en_drained: got %0d expected 0", fifo_count); end
    trace_en = 1'b1; trace_in = mk_pkt(32'h405);
    step();
    trace_in = mk_pkt(32'h406);
    checks++; if (trace_out_valid !== 1'b1 || trace_out !== mk_pkt(32'h405) || trace_out_ovf !== 1'b1) begin errors++; $display("FAIL en_pending_kept: got v=%b %h ovf=%b expected 405 ovf=1", trace_out_valid, trace_out.trace_rv_i_insn_ip, trace_out_ovf); end
    step();
    trace_en = 1'b0;
    checks++; if (trace_out !== mk_pkt(32'h406) || trace_out_ovf !== 1'b0) begin errors++; $display("FAIL en_pending_cleared: got %h ovf=%b expected 406 ovf=0", trace_out.trace_rv_i_insn_ip, trace_out_ovf); end
    step();
  endtask

  task automatic test_reset_mid();
    trace_out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      trace_in = mk_pkt(32'h500 + 32'(i));
      step();
    end
    trace_en = 1'b0; trace_out_ready = 1'b1;
    step();
    trace_out_ready = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rm_three: got %0d expected 3", fifo_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (trace_out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rm_async: got v=%b cnt=%0d expected v=0 cnt=0", trace_out_valid, fifo_count); end
    checks++; if (ovf_cnt !== 16'd0 || trace_out_ovf !== 1'b0) begin errors++; $display("FAIL rm_async_ovf: got cnt=%0d ovf=%b expected 0 0", ovf_cnt, trace_out_ovf); end
    step();
    rst = 1'b0;
    step();
    trace_en = 1'b1; trace_in = mk_pkt(32'h510);
    step();
    trace_en = 1'b0;
    checks++; if (trace_out_valid !== 1'b1 || trace_out !== mk_pkt(32'h510) || trace_out_ovf !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL rm_first_push: got v=%b %h ovf=%b cnt=%0d expected 510 ovf=0 cnt=1", trace_out_valid, trace_out.trace_rv_i_insn_ip, trace_out_ovf, fifo_count); end
    trace_out_ready = 1'b1;
    step();
  endtask

  task automatic test_ovf_cnt_sat();
    trace_out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trace_in = mk_pkt(32'h600 + 32'(i));
      step();
    end
    trace_in = mk_pkt(32'h6FF);
    repeat (SAT_DROPS) step();
    checks++; if (ovf_cnt !== (CNT_ON ? 16'hFFFF : 16'd0)) begin errors++; $display("FAIL sat_value: got %h expected %h", ovf_cnt, CNT_ON ? 16'hFFFF : 16'd0); end
    ovf_cnt_clr = 1'b1;
    step();
    ovf_cnt_clr = 1'b0;
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL sat_clear_wins: got %h expected 0", ovf_cnt); end
    step();
    checks++; if (ovf_cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin errors++; $display("FAIL sat_recount: got %h expected %h", ovf_cnt, CNT_ON ? 16'd1 : 16'd0); end
    trace_en = 1'b0; trace_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_out !== mk_pkt(32'h600 + 32'(i)) || trace_out_ovf !== 1'b0) begin errors++; $display("FAIL sat_drain[%0d]: got %h ovf=%b expected %h ovf=0", i, trace_out.trace_rv_i_insn_ip, trace_out_ovf, 32'h600 + 32'(i)); end
      step();
    end
    checks++; if (trace_out_valid !== 1'b0) begin errors++; $display("FAIL sat_empty: got %b expected 0", trace_out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_push();
    test_overflow();
    test_full_push_pop();
    test_backpressure();
    test_en_off_pending();
    test_reset_mid();
    test_ovf_cnt_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
